// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : mips_ctrl_pkg                                           |
// | Description: Shared opcode constants, FSM state encoding, ALU and    |
// |              PC-source codes, and the one-hot instruction class      |
// |              record used by the multicycle MIPS controller.          |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package mips_ctrl_pkg;

  // Opcodes taken from inst[31:26]
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] c_ALU_ADD  = 2'b00;
  localparam logic [1:0] c_ALU_SUB  = 2'b01;
  localparam logic [1:0] c_ALU_FUNC = 2'b10;

  // Next-PC source select
  localparam logic [1:0] c_PC_SEQ    = 2'b00;
  localparam logic [1:0] c_PC_BRANCH = 2'b01;
  localparam logic [1:0] c_PC_JUMP   = 2'b10;

  // Controller states; encodings are visible on the debug state port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // One-hot instruction class
  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic addi;
    logic j;
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/op_class_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : op_class_dec                                            |
// | Description: Maps a 6-bit opcode to a one-hot instruction class and  |
// |              flags any opcode outside the supported set.             |
// | Ports      : opcode_i  [5:0] opcode to classify                      |
// |              class_o         one-hot class (all zero when illegal)   |
// |              illegal_o       opcode not supported                    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module op_class_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_t  class_o,
  output logic       illegal_o
);

  always_comb begin
    class_o   = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      c_OP_RTYPE: class_o.rtype = 1'b1;
      c_OP_LW:    class_o.lw    = 1'b1;
      c_OP_SW:    class_o.sw    = 1'b1;
      c_OP_BEQ:   class_o.beq   = 1'b1;
      c_OP_ADDI:  class_o.addi  = 1'b1;
      c_OP_J:     class_o.j     = 1'b1;
      default:    illegal_o     = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : multicycle_ctrl                                         |
// | Description: Five-state multicycle MIPS control FSM                  |
// |              (FETCH, DECODE, EXEC, MEM, WB).                         |
// | Ports      : clk, rst          clock, synchronous active-high reset  |
// |              opcode, zero      instruction opcode, ALU zero flag     |
// |              imem_ready        instruction word valid                |
// |              dmem_ready        data access complete                  |
// |              imem_req, ir_we   fetch request, IR load                |
// |              RegDst, reg_we, mem_to_reg, alu_src, alu_op             |
// |                                datapath controls                     |
// |              dmem_req, dmem_we data request / write enable           |
// |              pc_we, pc_src     PC update and source                  |
// |              illegal, retire   single-cycle status pulses            |
// |              state             current state (debug)                 |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       RegDst,
  output logic       reg_we,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       retire,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  logic [5:0] w_dec_in;
  op_class_t  w_cls;
  logic       w_illegal;

  // One decoder serves every state: in DECODE it classifies the live
  // opcode, afterwards it classifies the latched op_q.
  assign w_dec_in = (state_q == ST_DECODE) ? opcode : op_q;

  op_class_dec u_dec (
    .opcode_i  (w_dec_in),
    .class_o   (w_cls),
    .illegal_o (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    RegDst     = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = c_ALU_ADD;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    pc_src     = c_PC_SEQ;
    illegal    = 1'b0;
    retire     = 1'b0;
    state      = state_q;

    unique case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_src  = c_PC_SEQ;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        op_d = opcode;
        if (w_illegal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (w_cls.j) begin
          pc_we   = 1'b1;
          pc_src  = c_PC_JUMP;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (w_cls.rtype | w_cls.lw | w_cls.sw | w_cls.beq | w_cls.addi) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_EXEC: begin
        if (w_cls.rtype) begin
          alu_op  = c_ALU_FUNC;
          state_d = ST_WB;
        end else if (w_cls.addi) begin
          alu_src = 1'b1;
          state_d = ST_WB;
        end else if (w_cls.lw | w_cls.sw) begin
          alu_src = 1'b1;
          state_d = ST_MEM;
        end else if (w_cls.beq) begin
          alu_op  = c_ALU_SUB;
          pc_we   = zero;
          pc_src  = c_PC_BRANCH;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_cls.sw;
        if (dmem_ready) begin
          if (w_cls.lw) begin
            state_d = ST_WB;
          end else begin
            retire  = w_cls.sw;
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        RegDst     = w_cls.rtype;
        mem_to_reg = w_cls.lw;
        state_d    = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset silences every output in the same cycle so an in-flight
    // fetch or data access is dropped without a stray write enable.
    if (rst) begin
      state_d    = ST_FETCH;
      op_d       = '0;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      RegDst     = 1'b0;
      reg_we     = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = c_ALU_ADD;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_we      = 1'b0;
      pc_src     = c_PC_SEQ;
      illegal    = 1'b0;
      retire     = 1'b0;
      state      = 3'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_multicycle_ctrl                                      |
// | Description: Self-checking bench for multicycle_ctrl. A route-based  |
// |              instruction model predicts every output each cycle;     |
// |              directed scenarios pin exact values; random traffic     |
// |              with stalls and resets follows.                         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero, imem_ready, dmem_ready;
  logic       imem_req, ir_we, RegDst, reg_we, mem_to_reg, alu_src;
  logic [1:0] alu_op;
  logic       dmem_req, dmem_we, pc_we;
  logic [1:0] pc_src;
  logic       illegal, retire;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .RegDst     (RegDst),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .retire     (retire),
    .state      (state)
  );

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       RegDst;
    logic       reg_we;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       illegal;
    logic       retire;
    logic [2:0] state;
  } outs_t;

  outs_t w_dut;
  assign w_dut = {imem_req, ir_we, RegDst, reg_we, mem_to_reg, alu_src, alu_op,
                  dmem_req, dmem_we, pc_we, pc_src, illegal, retire, state};

  int checks = 0;
  int errors = 0;
  outs_t obs;

  // Model: each instruction walks a route of state numbers. FETCH and
  // DECODE are common; DECODE appends the class-specific tail.
  int         route[$];
  int         pos;
  logic [5:0] m_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B ||
           op == 6'h04 || op == 6'h08 || op == 6'h02;
  endfunction

  function automatic outs_t model_out(input int st, input logic [5:0] opr,
                                      input logic [5:0] opi, input logic z,
                                      input logic ir, input logic dr);
    outs_t o = '0;
    o.state = 3'(st);
    case (st)
      0: begin
        o.imem_req = 1'b1;
        if (ir) begin o.ir_we = 1'b1; o.pc_we = 1'b1; end
      end
      1: begin
        if (!is_legal(opi)) o.illegal = 1'b1;
        else if (opi == 6'h02) begin o.pc_we = 1'b1; o.pc_src = 2'b10; o.retire = 1'b1; end
      end
      2: begin
        if (opr == 6'h00) o.alu_op = 2'b10;
        else if (opr == 6'h04) begin
          o.alu_op = 2'b01; o.pc_we = z; o.pc_src = 2'b01; o.retire = 1'b1;
        end else o.alu_src = 1'b1;
      end
      3: begin
        o.dmem_req = 1'b1;
        o.dmem_we  = (opr == 6'h2B);
        o.retire   = dr && (opr == 6'h2B);
      end
      4: begin
        o.reg_we = 1'b1; o.retire = 1'b1;
        o.RegDst = (opr == 6'h00); o.mem_to_reg = (opr == 6'h23);
      end
      default: ;
    endcase
    return o;
  endfunction

  // Called at posedge+1: drives inputs, compares at mid-cycle, advances model.
  task automatic cycle(input logic r, input logic [5:0] op, input logic z,
                       input logic ir, input logic dr);
    outs_t exp;
    int cur;
    rst = r; opcode = op; zero = z; imem_ready = ir; dmem_ready = dr;
    #4;
    exp = r ? outs_t'(0) : model_out(route[pos], m_op, op, z, ir, dr);
    obs = w_dut;
    chk("model_outs", 32'(w_dut), 32'(exp));
    if (r) begin
      route = '{0, 1}; pos = 0; m_op = '0;
    end else begin
      cur = route[pos];
      if (!((cur == 0 && !ir) || (cur == 3 && !dr))) begin
        if (cur == 1) begin
          m_op = op;
          case (op)
            6'h00, 6'h08: begin route.push_back(2); route.push_back(4); end
            6'h23: begin route.push_back(2); route.push_back(3); route.push_back(4); end
            6'h2B: begin route.push_back(2); route.push_back(3); end
            6'h04: route.push_back(2);
            default: ;
          endcase
        end
        pos++;
        if (pos >= route.size()) begin route = '{0, 1}; pos = 0; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops_tbl [8];
  logic [11:0] st_hist;
  int dreq_cnt, dwe_cnt, ret_at;

  initial begin
    route = '{0, 1}; pos = 0; m_op = '0;
    rst = 1'b1; opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset: all outputs low
    cycle(1, 6'h00, 1, 1, 1);
    chk("reset_outs", 32'(obs), 32'h0);
    cycle(1, 6'h3F, 0, 0, 0);

    // add, readys high: states 0,1,2,4 then back to 0
    st_hist = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 6'h00, 0, 1, 1);
      st_hist = {st_hist[8:0], obs.state};
      if (i == 3) begin
        chk("add_wb_regdst", 32'(obs.RegDst), 32'd1);
        chk("add_wb_reg_we", 32'(obs.reg_we), 32'd1);
        chk("add_wb_retire", 32'(obs.retire), 32'd1);
      end
    end
    chk("add_state_seq", 32'(st_hist), 32'(12'b000_001_010_100));

    // lw, dmem_ready high outside MEM (ignored), low for 3 MEM cycles
    dreq_cnt = 0; dwe_cnt = 0; ret_at = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 6'h23, 0, 1, (i < 3 || i > 5) ? 1'b1 : 1'b0);
      if (i == 0) chk("lw_start_fetch", 32'(obs.state), 32'd0);
      if (obs.dmem_req) dreq_cnt++;
      if (obs.dmem_we) dwe_cnt++;
      if (obs.retire && ret_at < 0) ret_at = i;
      if (i == 7) begin
        chk("lw_wb_mem_to_reg", 32'(obs.mem_to_reg), 32'd1);
        chk("lw_wb_regdst", 32'(obs.RegDst), 32'd0);
      end
    end
    chk("lw_dmem_req_cycles", 32'(dreq_cnt), 32'd4);
    chk("lw_dmem_we_cycles", 32'(dwe_cnt), 32'd0);
    chk("lw_retire_cycle", 32'(ret_at), 32'd7);

    // beq taken then not taken
    for (int i = 0; i < 3; i++) cycle(0, 6'h04, 1, 1, 1);
    chk("beq_z1_pc_we", 32'(obs.pc_we), 32'd1);
    chk("beq_z1_pc_src", 32'(obs.pc_src), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 6'h04, 0, 1, 1);
      if (i == 0) chk("beq_back_to_fetch", 32'(obs.state), 32'd0);
    end
    chk("beq_z0_pc_we", 32'(obs.pc_we), 32'd0);

    // illegal opcode
    cycle(0, 6'h3F, 0, 1, 1);
    chk("ill_fetch_state", 32'(obs.state), 32'd0);
    cycle(0, 6'h3F, 0, 1, 1);
    chk("ill_pulse", 32'(obs.illegal), 32'd1);
    chk("ill_no_enables", 32'({obs.reg_we, obs.dmem_req, obs.pc_we}), 32'd0);

    // sw with reset during the MEM wait
    for (int i = 0; i < 4; i++) begin
      cycle(0, 6'h2B, 0, 1, 1'b0);
      if (i == 0) chk("ill_next_fetch", 32'(obs.state), 32'd0);
    end
    chk("sw_mem_dmem_req", 32'(obs.dmem_req), 32'd1);
    cycle(1, 6'h2B, 0, 1, 1);
    chk("sw_rst_all_zero", 32'(obs), 32'd0);
    cycle(0, 6'h2B, 0, 0, 1);
    chk("sw_rst_fetch_req", 32'({obs.state, obs.imem_req}), 32'b0001);

    // j, readys high: 2 cycles
    cycle(0, 6'h02, 0, 1, 1);
    cycle(0, 6'h02, 0, 1, 1);
    chk("j_pc_src", 32'({obs.pc_we, obs.pc_src, obs.retire}), 32'b1101);

    // Random traffic with stalls, changing opcodes and occasional reset
    ops_tbl[0] = 6'h00; ops_tbl[1] = 6'h23; ops_tbl[2] = 6'h2B; ops_tbl[3] = 6'h04;
    ops_tbl[4] = 6'h08; ops_tbl[5] = 6'h02; ops_tbl[6] = 6'h3F; ops_tbl[7] = 6'h00;
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      int k;
      k = int'($urandom_range(0, 8));
      op = (k == 8) ? 6'($urandom) : ops_tbl[k];
      cycle(($urandom_range(0, 99) == 0), op, 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
